// File: rtl/fetch_redirect.sv
// Fetch PC register with branch redirect from MEMORY, flush generation, and
// a redirect held across fetch stalls until the stall releases.
module fetch_redirect #(
  parameter int              N        = 64,
  parameter logic [N-1:0]    RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCSrc_M,
  input  logic [N-1:0]     PCBranch_M,
  input  logic             stall_F,
  output logic [N-1:0]     PC_F,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_M,
  output logic             pending,
  output logic [CNT_W-1:0] redirect_count,
  output logic             misalign_err
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  typedef struct packed {
    logic         taken;
    logic         misalign;
    logic [N-1:0] target;
  } redir_req_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_SEQ  = 2'd1,
    PC_BR   = 2'd2,
    PC_PEND = 2'd3
  } pc_sel_t;

  localparam logic [N-1:0] PC_STEP = N'(4);

  state_t     state, state_nxt;
  redir_req_t req;
  logic [N-1:0] pend_tgt;
  logic       accept;
  logic       latch_en;
  pc_sel_t    pc_sel;

  // Targets are always word-aligned before use; the low bits only feed the error flag.
  always_comb begin
    req.taken    = PCSrc_M;
    req.misalign = |PCBranch_M[1:0];
    req.target   = {PCBranch_M[N-1:2], 2'b00};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:  if (req.taken && stall_F) state_nxt = PEND;
      PEND: if (!stall_F)             state_nxt = RUN;
      default:                        state_nxt = RUN;
    endcase
  end

  always_comb begin
    flush_D  = 1'b0;
    flush_E  = 1'b0;
    flush_M  = 1'b0;
    accept   = 1'b0;
    latch_en = 1'b0;
    pc_sel   = PC_HOLD;
    case (state)
      RUN: begin
        if (req.taken) begin
          flush_D  = 1'b1;
          flush_E  = 1'b1;
          flush_M  = 1'b1;
          accept   = 1'b1;
          latch_en = stall_F;
          pc_sel   = stall_F ? PC_HOLD : PC_BR;
        end else if (!stall_F) begin
          pc_sel   = PC_SEQ;
        end
      end
      PEND: begin
        // Only the instruction fetched from the held PC is still wrong-path.
        if (!stall_F) begin
          flush_D = 1'b1;
          pc_sel  = PC_PEND;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC_F <= RESET_PC;
    end else begin
      case (pc_sel)
        PC_SEQ:  PC_F <= PC_F + PC_STEP;
        PC_BR:   PC_F <= req.target;
        PC_PEND: PC_F <= pend_tgt;
        default: PC_F <= PC_F;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        pend_tgt <= '0;
    else if (latch_en) pend_tgt <= req.target;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect_count <= '0;
      misalign_err   <= 1'b0;
    end else if (accept) begin
      if (redirect_count != {CNT_W{1'b1}})
        redirect_count <= redirect_count + CNT_W'(1);
      if (req.misalign)
        misalign_err <= 1'b1;
    end
  end

  assign pending = (state == PEND);

endmodule
